// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_mon_pkg;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Width used for the tolerance arithmetic; wide enough that no operand wraps.
  localparam int DIFF_W = 32;

  // Absolute difference of two unsigned values.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                 input logic [DIFF_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input plus a rising-edge detector.
// Latency from input rise to the sampled rise pulse is STAGES+1 clock edges.
// STAGES must be at least 2.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              hist;

  // Shift the asynchronous input through the synchronizer and keep one history bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], async_in};
      hist <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~hist;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock health monitor: measures the period of clk_div in clk_in cycles,
// compares it with exp_period and reports lock, sticky fault and loss-of-clock.
//
// Handshake: period_valid is a single-cycle strobe with no back-pressure; period
// is stable from the strobe until the next strobe (or reset).
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int MAX_PERIOD  = 1024,
  parameter int CNT_W       = $clog2(MAX_PERIOD + 1),
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_period,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic             timeout,
  output state_t           dbg_state
);

  localparam int                GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_COUNT);
  localparam logic [DIFF_W-1:0] TOL_W    = DIFF_W'(TOL);

  state_t            state;
  state_t            state_next;
  logic              rise;
  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  counter_next;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_next;
  logic [CNT_W-1:0]  period_next;
  logic              pv_next;
  logic              locked_next;
  logic              fault_next;
  logic              fault_set;
  logic              timeout_next;
  logic              in_tol;

  edge_sync #(
    .STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .async_in (clk_div),
    .rise     (rise)
  );

  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: disable always wins, a timeout drops back to ARM.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_next = ARM;
        ARM:     if (rise) state_next = MEASURE;
        MEASURE: if (!rise && (counter == MAX_CNT)) state_next = ARM;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and output decisions for the current cycle.
  always_comb begin
    counter_next = counter;
    good_next    = good_cnt;
    period_next  = period;
    pv_next      = 1'b0;
    locked_next  = locked;
    timeout_next = 1'b0;
    fault_set    = 1'b0;
    in_tol       = abs_diff(DIFF_W'(counter), DIFF_W'(exp_period)) <= TOL_W;

    if (!en) begin
      counter_next = '0;
      good_next    = '0;
      locked_next  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          counter_next = '0;
          good_next    = '0;
        end
        ARM: begin
          // First rise only starts the count; it is not a measurement.
          if (rise) counter_next = CNT_W'(1);
        end
        MEASURE: begin
          if (rise) begin
            // A rise on the MAX_PERIOD cycle is still a valid measurement.
            period_next  = counter;
            pv_next      = 1'b1;
            counter_next = CNT_W'(1);
            if (in_tol) begin
              if (good_cnt != LOCK_CNT) good_next = good_cnt + GOOD_W'(1);
              if (good_next == LOCK_CNT) locked_next = 1'b1;
            end else begin
              good_next   = '0;
              locked_next = 1'b0;
              fault_set   = 1'b1;
            end
          end else if (counter == MAX_CNT) begin
            timeout_next = 1'b1;
            fault_set    = 1'b1;
            locked_next  = 1'b0;
            good_next    = '0;
            counter_next = '0;
          end else begin
            counter_next = counter + CNT_W'(1);
          end
        end
        default: begin
          counter_next = '0;
          good_next    = '0;
        end
      endcase
    end

    // Setting the sticky fault takes priority over a simultaneous clear.
    if (fault_set) begin
      fault_next = 1'b1;
    end else if (fault_clr) begin
      fault_next = 1'b0;
    end else begin
      fault_next = fault;
    end
  end

  // Register the counters and all outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      counter      <= '0;
      good_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      counter      <= counter_next;
      good_cnt     <= good_next;
      period       <= period_next;
      period_valid <= pv_next;
      locked       <= locked_next;
      fault        <= fault_next;
      timeout      <= timeout_next;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor with a synchronous programmable divider.
module tb_clk_div_monitor;
  import clk_mon_pkg::*;

  localparam int MAX_P  = 16;
  localparam int TOL_P  = 1;
  localparam int LOCK_P = 4;
  localparam int SYNC_P = 2;
  localparam int CNT_W  = $clog2(MAX_P + 1);
  localparam int EW     = CNT_W + 2;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             clk_div;
  logic             en;
  logic [CNT_W-1:0] exp_period;
  logic             fault_clr;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             fault;
  logic             timeout;
  state_t           dbg_state;

  int n_cmp      = 0;
  int n_bad      = 0;
  int div_n      = 0;
  int phase      = -1;
  int rise_count = 0;
  int to_seen    = 0;

  // Expected {fault, locked, period} per period_valid strobe.
  logic [EW-1:0] exp_q[$];

  clk_div_monitor #(
    .MAX_PERIOD  (MAX_P),
    .TOL         (TOL_P),
    .LOCK_COUNT  (LOCK_P),
    .SYNC_STAGES (SYNC_P)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .clk_div      (clk_div),
    .en           (en),
    .exp_period   (exp_period),
    .fault_clr    (fault_clr),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  initial forever #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

  // Divider model: div_n = 0 holds clk_div low; otherwise rises every div_n cycles.
  initial begin
    clk_div = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (div_n == 0) begin
        phase   = -1;
        clk_div = 1'b0;
      end else begin
        phase++;
        if (phase >= div_n) phase = 0;
        if ((phase < div_n / 2) && !clk_div) rise_count++;
        clk_div = (phase < div_n / 2);
      end
    end
  end

  // Driver helpers
  task automatic push_exp(input logic f, input logic l, input int p);
    exp_q.push_back({f, l, CNT_W'(p)});
  endtask

  task automatic wait_pv(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (timeout) to_seen++;
      if (period_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    @(negedge clk_in);
    fault_clr = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; fault_clr = 1'b0; exp_period = CNT_W'(4); div_n = 0;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if ({period, period_valid, locked, fault, timeout} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got p=%0d pv=%0b l=%0b f=%0b t=%0b want all 0",
               period, period_valid, locked, fault, timeout);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_bad++; $display("FAIL reset_release_state: got %0d want IDLE", dbg_state);
    end
  endtask

  task automatic test_lock_div4();
    bit got;
    logic [EW-1:0] exp;
    div_n = 4; exp_period = CNT_W'(4); en = 1'b1;
    for (int k = 0; k < 6; k++) push_exp(1'b0, k >= 3, 4);
    for (int k = 0; k < 6; k++) begin
      wait_pv(40, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL lock_div4 pv%0d: got no strobe want strobe", k);
      end else begin
        exp = exp_q.pop_front();
        if ({fault, locked, period} !== exp) begin
          n_bad++;
          $display("FAIL lock_div4 pv%0d: got f=%0b l=%0b p=%0d want f=%0b l=%0b p=%0d", k,
                   fault, locked, period, exp[EW-1], exp[EW-2], exp[CNT_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_tolerance();
    bit got;
    logic [EW-1:0] exp;
    exp_period = CNT_W'(5);
    for (int k = 0; k < 2; k++) push_exp(1'b0, 1'b1, 4);
    for (int k = 0; k < 2; k++) begin
      wait_pv(40, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL tolerance pv%0d: got no strobe want strobe", k);
      end else begin
        exp = exp_q.pop_front();
        if ({fault, locked, period} !== exp) begin
          n_bad++;
          $display("FAIL tolerance pv%0d: got f=%0b l=%0b p=%0d want f=%0b l=%0b p=%0d", k,
                   fault, locked, period, exp[EW-1], exp[EW-2], exp[CNT_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_mismatch();
    bit got;
    logic [EW-1:0] exp;
    en = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++; $display("FAIL mismatch_en_off_locked: got %0b want 0", locked);
    end
    div_n = 6; exp_period = CNT_W'(4);
    repeat (8) @(negedge clk_in);
    en = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(1'b1, 1'b0, 6);
    for (int k = 0; k < 3; k++) begin
      wait_pv(40, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL mismatch pv%0d: got no strobe want strobe", k);
      end else begin
        exp = exp_q.pop_front();
        if ({fault, locked, period} !== exp) begin
          n_bad++;
          $display("FAIL mismatch pv%0d: got f=%0b l=%0b p=%0d want f=%0b l=%0b p=%0d", k,
                   fault, locked, period, exp[EW-1], exp[EW-2], exp[CNT_W-1:0]);
        end
      end
    end
    // Clear lands on the same edge as the next mismatch detection: set wins.
    repeat (5) @(negedge clk_in);
    fault_clr = 1'b1;
    @(negedge clk_in);
    fault_clr = 1'b0;
    n_cmp++;
    if ({period_valid, fault, period} !== {1'b1, 1'b1, CNT_W'(6)}) begin
      n_bad++;
      $display("FAIL clr_collision: got pv=%0b f=%0b p=%0d want pv=1 f=1 p=6",
               period_valid, fault, period);
    end
    // Clear on a quiet edge takes effect.
    pulse_clr();
    n_cmp++;
    if (fault !== 1'b0) begin
      n_bad++; $display("FAIL clr_quiet: got f=%0b want 0", fault);
    end
  endtask

  task automatic test_timeout();
    bit got;
    logic [EW-1:0] exp;
    int to_cnt, pv_cnt, first_to;
    logic to_locked, to_fault;
    en = 1'b0;
    pulse_clr();
    div_n = 4; exp_period = CNT_W'(4);
    repeat (4) @(negedge clk_in);
    en = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(1'b0, k == 3, 4);
    for (int k = 0; k < 4; k++) begin
      wait_pv(40, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL timeout_lock pv%0d: got no strobe want strobe", k);
      end else begin
        exp = exp_q.pop_front();
        if ({fault, locked, period} !== exp) begin
          n_bad++;
          $display("FAIL timeout_lock pv%0d: got f=%0b l=%0b p=%0d want f=%0b l=%0b p=%0d", k,
                   fault, locked, period, exp[EW-1], exp[EW-2], exp[CNT_W-1:0]);
        end
      end
    end
    // Stop the clock right after the last strobe; the pending rise is suppressed.
    div_n = 0;
    to_cnt = 0; pv_cnt = 0; first_to = -1; to_locked = 1'b1; to_fault = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_in);
      if (period_valid) pv_cnt++;
      if (timeout) begin
        to_cnt++;
        if (first_to < 0) begin
          first_to = i; to_locked = locked; to_fault = fault;
        end
      end
    end
    n_cmp++;
    if (to_cnt !== 1 || first_to !== MAX_P) begin
      n_bad++;
      $display("FAIL timeout_pulse: got count=%0d at=%0d want count=1 at=%0d", to_cnt, first_to, MAX_P);
    end
    n_cmp++;
    if ({to_locked, to_fault} !== 2'b01 || pv_cnt !== 0) begin
      n_bad++;
      $display("FAIL timeout_flags: got l=%0b f=%0b pv=%0d want l=0 f=1 pv=0", to_locked, to_fault, pv_cnt);
    end
    // Restart: first strobe comes with the second rise.
    rise_count = 0;
    div_n = 4;
    push_exp(1'b1, 1'b0, 4);
    wait_pv(40, got);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL timeout_restart: got no strobe want strobe");
    end else begin
      exp = exp_q.pop_front();
      if ({fault, locked, period} !== exp || rise_count !== 2) begin
        n_bad++;
        $display("FAIL timeout_restart: got f=%0b l=%0b p=%0d rises=%0d want f=%0b l=%0b p=%0d rises=2",
                 fault, locked, period, rise_count, exp[EW-1], exp[EW-2], exp[CNT_W-1:0]);
      end
    end
  endtask

  task automatic test_boundary();
    bit got;
    logic [EW-1:0] exp;
    int to_cnt, pv_cnt;
    en = 1'b0;
    pulse_clr();
    div_n = MAX_P; exp_period = CNT_W'(MAX_P);
    repeat (4) @(negedge clk_in);
    to_seen = 0;
    en = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(1'b0, k == 3, MAX_P);
    for (int k = 0; k < 4; k++) begin
      wait_pv(60, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL boundary16 pv%0d: got no strobe want strobe", k);
      end else begin
        exp = exp_q.pop_front();
        if ({fault, locked, period} !== exp) begin
          n_bad++;
          $display("FAIL boundary16 pv%0d: got f=%0b l=%0b p=%0d want f=%0b l=%0b p=%0d", k,
                   fault, locked, period, exp[EW-1], exp[EW-2], exp[CNT_W-1:0]);
        end
      end
    end
    n_cmp++;
    if (to_seen !== 0) begin
      n_bad++; $display("FAIL boundary16_timeout: got %0d timeouts want 0", to_seen);
    end
    en = 1'b0;
    div_n = MAX_P + 1; exp_period = CNT_W'(MAX_P + 1);
    repeat (4) @(negedge clk_in);
    en = 1'b1;
    to_cnt = 0; pv_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_in);
      if (timeout) to_cnt++;
      if (period_valid) pv_cnt++;
    end
    n_cmp++;
    if (pv_cnt !== 0 || to_cnt < 1 || fault !== 1'b1) begin
      n_bad++;
      $display("FAIL boundary17: got pv=%0d to=%0d f=%0b want pv=0 to>=1 f=1", pv_cnt, to_cnt, fault);
    end
  endtask

  task automatic test_en_drop();
    bit got;
    logic [EW-1:0] exp;
    int pv_cnt;
    en = 1'b0;
    pulse_clr();
    div_n = 4; exp_period = CNT_W'(4);
    repeat (4) @(negedge clk_in);
    en = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(1'b0, k >= 3, 4);
    for (int k = 0; k < 5; k++) begin
      wait_pv(40, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL en_drop_lock pv%0d: got no strobe want strobe", k);
      end else begin
        exp = exp_q.pop_front();
        if ({fault, locked, period} !== exp) begin
          n_bad++;
          $display("FAIL en_drop_lock pv%0d: got f=%0b l=%0b p=%0d want f=%0b l=%0b p=%0d", k,
                   fault, locked, period, exp[EW-1], exp[EW-2], exp[CNT_W-1:0]);
        end
      end
    end
    // Drop enable on the very edge a rise is detected.
    repeat (3) @(negedge clk_in);
    en = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if ({period_valid, locked, period} !== {1'b0, 1'b0, CNT_W'(4)} || dbg_state !== IDLE) begin
      n_bad++;
      $display("FAIL en_drop: got pv=%0b l=%0b p=%0d st=%0d want pv=0 l=0 p=4 st=IDLE",
               period_valid, locked, period, dbg_state);
    end
    pv_cnt = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (period_valid) pv_cnt++;
    end
    n_cmp++;
    if (pv_cnt !== 0) begin
      n_bad++; $display("FAIL en_drop_quiet: got %0d strobes want 0", pv_cnt);
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(1'b0, k == 3, 4);
    for (int k = 0; k < 4; k++) begin
      wait_pv(40, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL en_relock pv%0d: got no strobe want strobe", k);
      end else begin
        exp = exp_q.pop_front();
        if ({fault, locked, period} !== exp) begin
          n_bad++;
          $display("FAIL en_relock pv%0d: got f=%0b l=%0b p=%0d want f=%0b l=%0b p=%0d", k,
                   fault, locked, period, exp[EW-1], exp[EW-2], exp[CNT_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (2) @(negedge clk_in);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({period, period_valid, locked, fault, timeout} !== '0 || dbg_state !== IDLE) begin
      n_bad++;
      $display("FAIL async_reset: got p=%0d pv=%0b l=%0b f=%0b t=%0b st=%0d want all 0 st=IDLE",
               period, period_valid, locked, fault, timeout, dbg_state);
    end
    en = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if (dbg_state !== IDLE || locked !== 1'b0) begin
      n_bad++; $display("FAIL reset_return: got st=%0d l=%0b want st=IDLE l=0", dbg_state, locked);
    end
    en = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (dbg_state !== ARM) begin
      n_bad++; $display("FAIL reset_rearm: got st=%0d want ARM", dbg_state);
    end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_lock_div4();
    test_tolerance();
    test_mismatch();
    test_timeout();
    test_boundary();
    test_en_drop();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
